// File: rtl/hive_thrd_sched_if.sv
// Bus between the barrel-processor thread scheduler and its environment:
// stage-0 thread id, interrupt lines, register port and the PC-ring strobes.
interface hive_thrd_sched_if #(
    parameter int unsigned THRDS = 8,
    parameter int unsigned ID_W  = 3
);
    logic [ID_W-1:0]  id_i;
    logic [THRDS-1:0] irq_req_i;
    logic             irt_i;
    logic             reg_wr_i;
    logic [1:0]       reg_sel_i;
    logic [THRDS-1:0] reg_wdata_i;
    logic [THRDS-1:0] reg_rdata_o;
    logic             clt_o;
    logic             irq_o;

    modport master (
        output id_i, irq_req_i, irt_i, reg_wr_i, reg_sel_i, reg_wdata_i,
        input  reg_rdata_o, clt_o, irq_o
    );

    modport slave (
        input  id_i, irq_req_i, irt_i, reg_wr_i, reg_sel_i, reg_wdata_i,
        output reg_rdata_o, clt_o, irq_o
    );
endinterface

// File: rtl/hive_thrd_sched.sv
// Per-thread clear/interrupt scheduler: tracks en/clr/pend/ist per thread and
// issues clt/irq strobes one cycle ahead so they line up with the thread at stage 0.
module hive_thrd_sched #(
    parameter int unsigned THRDS  = 8,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned SYNC_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hive_thrd_sched_if.slave bus
);
    localparam logic [1:0] SEL_EN   = 2'd0;
    localparam logic [1:0] SEL_CLR  = 2'd1;
    localparam logic [1:0] SEL_PEND = 2'd2;
    localparam logic [1:0] SEL_IST  = 2'd3;

    logic [SYNC_W-1:0][THRDS-1:0] sync_q;
    logic [THRDS-1:0] hist_q;
    logic [THRDS-1:0] edge_c;

    logic [THRDS-1:0] en_q, en_d;
    logic [THRDS-1:0] clr_q, clr_d;
    logic [THRDS-1:0] pend_q, pend_d;
    logic [THRDS-1:0] ist_q, ist_d;
    logic             clt_q, clt_d;
    logic             irq_q, irq_d;

    logic [ID_W-1:0]  nxt_id;
    logic [THRDS-1:0] nxt_oh, cur_oh;
    logic             wr_en, wr_clr, wr_pend, wr_ist;
    logic [THRDS-1:0] issue_clr_m, issue_set_m, irt_clr_m;

    // Synchronizer chain (index 0 nearest the pin) plus history flop for edge detect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_W-2:0], bus.irq_req_i};
            hist_q <= sync_q[SYNC_W-1];
        end
    end

    assign edge_c = sync_q[SYNC_W-1] & ~hist_q;

    // Issue decision for the thread arriving at stage 0 next cycle
    always_comb begin
        nxt_id  = bus.id_i + ID_W'(1);
        nxt_oh  = THRDS'(1) << nxt_id;
        cur_oh  = THRDS'(1) << bus.id_i;
        clt_d   = clr_q[nxt_id];
        irq_d   = ~clr_q[nxt_id] & en_q[nxt_id] & pend_q[nxt_id] & ~ist_q[nxt_id];
        wr_en   = bus.reg_wr_i && (bus.reg_sel_i == SEL_EN);
        wr_clr  = bus.reg_wr_i && (bus.reg_sel_i == SEL_CLR);
        wr_pend = bus.reg_wr_i && (bus.reg_sel_i == SEL_PEND);
        wr_ist  = bus.reg_wr_i && (bus.reg_sel_i == SEL_IST);
        issue_clr_m = (clt_d || irq_d) ? nxt_oh : '0;
        issue_set_m = irq_d ? nxt_oh : '0;
        irt_clr_m   = bus.irt_i ? cur_oh : '0;
    end

    // Next state: all clears first, then sets, so a coincident set wins
    always_comb begin
        en_d   = en_q;
        clr_d  = clr_q;
        pend_d = pend_q;
        ist_d  = ist_q;
        if (wr_en) begin
            en_d = bus.reg_wdata_i;
        end
        clr_d  = (clr_q & ~(clt_d ? nxt_oh : '0))
               | (wr_clr ? bus.reg_wdata_i : '0);
        pend_d = (pend_q & ~issue_clr_m)
               | edge_c
               | (wr_pend ? bus.reg_wdata_i : '0);
        ist_d  = (ist_q & ~(clt_d ? nxt_oh : '0) & ~irt_clr_m
                        & ~(wr_ist ? bus.reg_wdata_i : '0))
               | issue_set_m;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q   <= '0;
            clr_q  <= '0;
            pend_q <= '0;
            ist_q  <= '0;
            clt_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            clr_q  <= clr_d;
            pend_q <= pend_d;
            ist_q  <= ist_d;
            clt_q  <= clt_d;
            irq_q  <= irq_d;
        end
    end

    // Read mux shows register state ahead of any write landing this cycle
    always_comb begin
        bus.reg_rdata_o = '0;
        case (bus.reg_sel_i)
            SEL_EN:   bus.reg_rdata_o = en_q;
            SEL_CLR:  bus.reg_rdata_o = clr_q;
            SEL_PEND: bus.reg_rdata_o = pend_q;
            SEL_IST:  bus.reg_rdata_o = ist_q;
            default:  bus.reg_rdata_o = '0;
        endcase
    end

    assign bus.clt_o = clt_q;
    assign bus.irq_o = irq_q;
endmodule

// File: tb/tb_hive_thrd_sched.sv
// Bench for hive_thrd_sched: directed scenarios and random traffic checked
// every cycle against a per-thread rule model of the scheduler.
module tb_hive_thrd_sched;
    localparam int unsigned THRDS  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned SYNC_W = 2;
    localparam logic [1:0] SEL_EN   = 2'd0;
    localparam logic [1:0] SEL_CLR  = 2'd1;
    localparam logic [1:0] SEL_PEND = 2'd2;
    localparam logic [1:0] SEL_IST  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hive_thrd_sched_if #(.THRDS(THRDS), .ID_W(ID_W)) bus ();

    hive_thrd_sched #(.THRDS(THRDS), .ID_W(ID_W), .SYNC_W(SYNC_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model state
    logic [THRDS-1:0] m_en, m_clr, m_pend, m_ist;
    logic             m_clt, m_irq;
    logic [THRDS-1:0] pin_log[$];
    int               irq_seen[THRDS];
    int               clt_seen[THRDS];
    int               n_assert = 0;
    int               n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [THRDS-1:0] model_read(input logic [1:0] sel);
        case (sel)
            SEL_EN:   return m_en;
            SEL_CLR:  return m_clr;
            SEL_PEND: return m_pend;
            default:  return m_ist;
        endcase
    endfunction

    task automatic model_reset();
        m_en = '0; m_clr = '0; m_pend = '0; m_ist = '0;
        m_clt = 1'b0; m_irq = 1'b0;
        pin_log.delete();
        repeat (SYNC_W + 1) pin_log.push_back('0);
    endtask

    // One clock of the scheduler rules, using the inputs present at the edge
    task automatic model_edge();
        int c, n, sz;
        logic [THRDS-1:0] edge_ev, wd;
        logic wr;
        c  = int'(bus.id_i);
        n  = (c + 1) % THRDS;
        wr = bus.reg_wr_i;
        wd = bus.reg_wdata_i;
        pin_log.push_back(bus.irq_req_i);
        sz = pin_log.size();
        // a pin level rises into view SYNC_W samples after it was taken
        edge_ev = pin_log[sz-1-SYNC_W] & ~pin_log[sz-2-SYNC_W];
        if (sz > SYNC_W + 2) pin_log.pop_front();
        m_clt = 1'b0;
        m_irq = 1'b0;
        if (m_clr[n]) begin
            m_clt = 1'b1;
            m_clr[n] = 1'b0; m_pend[n] = 1'b0; m_ist[n] = 1'b0;
        end else if (m_en[n] && m_pend[n] && !m_ist[n]) begin
            m_irq = 1'b1;
            m_pend[n] = 1'b0;
        end
        if (bus.irt_i) m_ist[c] = 1'b0;
        if (wr && bus.reg_sel_i == SEL_IST)  m_ist  = m_ist & ~wd;
        if (wr && bus.reg_sel_i == SEL_EN)   m_en   = wd;
        if (wr && bus.reg_sel_i == SEL_CLR)  m_clr  = m_clr | wd;
        if (wr && bus.reg_sel_i == SEL_PEND) m_pend = m_pend | wd;
        m_pend = m_pend | edge_ev;
        if (m_irq) m_ist[n] = 1'b1;
    endtask

    task automatic clear_seen();
        for (int t = 0; t < THRDS; t++) begin
            irq_seen[t] = 0;
            clt_seen[t] = 0;
        end
    endtask

    // Advance one clock, check the strobes and read data, then present the next id
    task automatic tick();
        int nn;
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk("clt_o", 32'(bus.clt_o), 32'(m_clt));
        chk("irq_o", 32'(bus.irq_o), 32'(m_irq));
        chk("clt_irq_excl", 32'(bus.clt_o & bus.irq_o), 32'd0);
        chk("reg_rdata", 32'(bus.reg_rdata_o), 32'(model_read(bus.reg_sel_i)));
        nn = (int'(bus.id_i) + 1) % THRDS;
        if (bus.clt_o === 1'b1) clt_seen[nn]++;
        if (bus.irq_o === 1'b1) irq_seen[nn]++;
        bus.id_i     = bus.id_i + ID_W'(1);
        bus.reg_wr_i = 1'b0;
        bus.irt_i    = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [THRDS-1:0] data);
        bus.reg_wr_i    = 1'b1;
        bus.reg_sel_i   = sel;
        bus.reg_wdata_i = data;
        tick();
    endtask

    task automatic run_to(input int k);
        for (int i = 0; i < THRDS && int'(bus.id_i) != k; i++) tick();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] sel, input logic [THRDS-1:0] exp);
        bus.reg_sel_i = sel;
        #1;
        chk(tag, 32'(bus.reg_rdata_o), 32'(exp));
    endtask

    task automatic read_bit(input string tag, input logic [1:0] sel, input int b, input logic exp);
        bus.reg_sel_i = sel;
        #1;
        chk(tag, 32'(bus.reg_rdata_o[b]), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_clt_async", 32'(bus.clt_o), 32'd0);
        chk("rst_irq_async", 32'(bus.irq_o), 32'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.id_i = bus.id_i + ID_W'(1);
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic saw_clt;
        bus.id_i = '0; bus.irq_req_i = '0; bus.irt_i = 1'b0;
        bus.reg_wr_i = 1'b0; bus.reg_sel_i = SEL_EN; bus.reg_wdata_i = '0;
        model_reset();
        clear_seen();
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.id_i = bus.id_i + ID_W'(1);
        end
        chk("reset_clt", 32'(bus.clt_o), 32'd0);
        chk("reset_irq", 32'(bus.irq_o), 32'd0);
        rst = 1'b0;

        // Idle for three revolutions, rotating the read select
        for (int i = 0; i < 3 * THRDS; i++) begin
            bus.reg_sel_i = 2'(i);
            tick();
        end
        read_chk("idle_en", SEL_EN, 8'h00);
        read_chk("idle_clr", SEL_CLR, 8'h00);
        read_chk("idle_pend", SEL_PEND, 8'h00);
        read_chk("idle_ist", SEL_IST, 8'h00);

        // External edge on line 3
        wr_reg(SEL_EN, 8'h08);
        clear_seen();
        bus.irq_req_i[3] = 1'b1;
        repeat (3) tick();
        bus.irq_req_i[3] = 1'b0;
        repeat (13) tick();
        chk("t3_irq_once", 32'(irq_seen[3]), 32'd1);
        read_chk("t3_ist", SEL_IST, 8'h08);
        read_chk("t3_pend", SEL_PEND, 8'h00);
        clear_seen();
        repeat (2 * THRDS) tick();
        chk("t3_no_nest", 32'(irq_seen[3]), 32'd0);
        run_to(3);
        bus.irt_i = 1'b1;
        tick();
        read_chk("t3_ist_after_irt", SEL_IST, 8'h00);

        // CLR beats PEND on thread 2; thread 0 gets its irq
        wr_reg(SEL_EN, 8'hFF);
        run_to(5);
        wr_reg(SEL_PEND, 8'h05);
        wr_reg(SEL_CLR, 8'h04);
        clear_seen();
        repeat (THRDS) tick();
        chk("t0_irq", 32'(irq_seen[0]), 32'd1);
        chk("t2_clt", 32'(clt_seen[2]), 32'd1);
        chk("t2_no_irq", 32'(irq_seen[2]), 32'd0);
        read_bit("t2_pend_cleared", SEL_PEND, 2, 1'b0);

        // Second edge on thread 5 while in service waits for irt
        wr_reg(SEL_PEND, 8'h20);
        repeat (THRDS) tick();
        read_bit("t5_in_service", SEL_IST, 5, 1'b1);
        bus.irq_req_i[5] = 1'b1;
        clear_seen();
        repeat (THRDS) tick();
        chk("t5_held", 32'(irq_seen[5]), 32'd0);
        read_bit("t5_pend_held", SEL_PEND, 5, 1'b1);
        run_to(5);
        bus.irt_i = 1'b1;
        tick();
        clear_seen();
        repeat (THRDS) tick();
        chk("t5_irq_after_irt", 32'(irq_seen[5]), 32'd1);

        // PEND write coincident with issue evaluation of thread 6
        run_to(4);
        wr_reg(SEL_PEND, 8'h40);
        clear_seen();
        wr_reg(SEL_PEND, 8'h40);
        read_bit("t6_pend_kept", SEL_PEND, 6, 1'b1);
        repeat (THRDS) tick();
        chk("t6_irq_once", 32'(irq_seen[6]), 32'd1);
        read_bit("t6_pend_still", SEL_PEND, 6, 1'b1);

        // Reset in the middle of a loaded state
        bus.irq_req_i = '0;
        do_reset();
        wr_reg(SEL_EN, 8'h0F);
        wr_reg(SEL_PEND, 8'h0F);
        repeat (THRDS) tick();
        wr_reg(SEL_EN, 8'h00);
        wr_reg(SEL_PEND, 8'hFF);
        wr_reg(SEL_CLR, 8'h30);
        read_chk("pre_rst_pend", SEL_PEND, 8'hFF);
        read_chk("pre_rst_ist", SEL_IST, 8'h0F);
        read_chk("pre_rst_clr", SEL_CLR, 8'h30);
        saw_clt = 1'b0;
        for (int i = 0; i < 2 * THRDS && !saw_clt; i++) begin
            tick();
            saw_clt = (bus.clt_o === 1'b1);
        end
        chk("pre_rst_clt_seen", 32'(saw_clt), 32'd1);
        do_reset();
        read_chk("post_rst_en", SEL_EN, 8'h00);
        read_chk("post_rst_clr", SEL_CLR, 8'h00);
        read_chk("post_rst_pend", SEL_PEND, 8'h00);
        read_chk("post_rst_ist", SEL_IST, 8'h00);
        clear_seen();
        repeat (2 * THRDS) tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.irq_req_i = bus.irq_req_i ^ THRDS'($urandom & $urandom & $urandom);
            bus.reg_sel_i = 2'($urandom_range(0, 3));
            bus.reg_wr_i  = ($urandom_range(0, 3) == 0);
            bus.reg_wdata_i = THRDS'($urandom);
            bus.irt_i     = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hive_thrd_sched.md
Name: hive_thrd_sched

Overview:
- Per-thread clear/interrupt scheduler for the 8-thread barrel processor.
- Holds enable, pending-interrupt, in-service and clear-request state for every thread.
- Issues single-cycle clt_o / irq_o strobes to the PC ring, aligned to the cycle in which the target thread's id is presented at stage 0.
- Software access is through a small register port; external interrupt lines are synchronized and edge-detected here.

Parameters:
- THRDS, 8, number of threads (power of 2).
- ID_W, 3, thread id width, log2(THRDS).
- SYNC_W, 2, synchronizer depth for external irq lines (>=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- id_i  in  ID_W  thread id currently at stage 0; increments by 1 mod THRDS every clock.
- irq_req_i  in  THRDS  external interrupt lines, asynchronous, rising-edge significant.
- irt_i  in  1  thread id_i is executing interrupt return this cycle.
- reg_wr_i  in  1  register write strobe.
- reg_sel_i  in  2  register select: 0 EN, 1 CLR, 2 PEND, 3 IST.
- reg_wdata_i  in  THRDS  write data.
- reg_rdata_o  out  THRDS  read data of reg_sel_i (combinational mux of state registers).
- clt_o  out  1  clear-thread strobe for thread id_i (to PC ring clt_i).
- irq_o  out  1  interrupt strobe for thread id_i (to PC ring irq_i).

Behaviour:
- Reset: en, clr, pend, ist = 0. All synchronizer and edge flops = 0. clt_o = irq_o = 0.
- A line already high at reset release yields one edge event; this is intended.
- Synchronizer: SYNC_W flops per bit, plus one history flop. The rising edge (sync & ~hist) sets pend[t].
- Latency: request edge at pin to pend set = SYNC_W+1 clocks.
- Lookahead issue: outputs are registered. Each cycle, evaluate thread n = (id_i+1) mod THRDS; the result appears on clt_o/irq_o the next cycle, when id_i == n.
- Issue rule for thread n, in priority order:
  - clr[n] = 1: next clt_o = 1, irq_o = 0. Clear clr[n], pend[n] and ist[n].
  - Else en[n] & pend[n] & ~ist[n]: next irq_o = 1. Clear pend[n] and set ist[n].
  - Else both outputs 0.
- clt_o and irq_o are never both 1. No nesting: at most one irq per thread until that thread's irt.
- irt_i clears ist[id_i]. No effect if ist[id_i] is already 0.
- Register writes, applied at clock edge:
  - EN: en = wdata (replace).
  - CLR: clr |= wdata.
  - PEND: pend |= wdata (software-forced interrupt).
  - IST: ist &= ~wdata (write-1-to-clear).
- Simultaneous events on one bit in one cycle: set beats clear.
  - Edge or PEND write coincident with irq issue: pend remains 1, so a second irq follows after irt.
  - CLR write coincident with clt issue: clr remains 1, so another clt comes next revolution.
  - Issue-set of ist coincident with IST W1C: ist = 1.
  - irt_i clearing ist[id_i] coincides with issue-set of ist only for a different thread (n != id_i); both take effect.
- Disabling via EN while pend = 1: pend is held, and irq issues once re-enabled.
- Reset mid-operation: all state cleared asynchronously. Strobes drop immediately. Pending, in-service and clear requests are lost.
- Width rules: id arithmetic is mod THRDS (wrap 7 -> 0). reg_rdata_o for IST/PEND/CLR/EN reflects register state before the current-cycle write.

Test Plan:
- Reset release with id_i cycling 0..7 and no requests: clt_o = irq_o = 0 for 3 revolutions. All reads return 0x00.
- Write EN = 0x08, then pulse irq_req_i[3] 0->1: irq_o = 1 exactly in the next cycle with id_i = 3 after SYNC_W+1 clocks. Then IST reads 0x08 and PEND reads 0x00. No further irq until irt_i at id_i = 3, after which IST = 0x00.
- EN = 0xFF; write PEND = 0x05 and CLR = 0x04 in consecutive cycles before thread 2 is reached: thread 0 gets irq_o. Thread 2 gets clt_o (not irq_o), and PEND bit 2 is cleared.
- Thread 5 in service; a second irq_req_i[5] edge arrives: PEND bit 5 = 1, no irq_o. After irt_i at id 5, irq_o fires on thread 5's next slot. Verify clt_o is never asserted together with irq_o.
- Coincidence: PEND write of bit 6 in the same cycle as the issue evaluation for thread 6: one irq_o on thread 6, and PEND bit 6 still reads 1 afterwards.
- Assert rst_i mid-operation with PEND = 0xFF, IST = 0x0F, CLR = 0x30: outputs 0 asynchronously. After release, all registers read 0x00 and no strobes occur.
